// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receive stage and the peripheral register block.
// The slave modport is the receiver's view; master is the bus/baud-generator side.
interface uart_rx_if;
  logic       baud_tick;
  logic       rxd;
  logic       rx_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       overrun;
  logic       frame_err;
  logic       rx_busy;

  modport slave (
    input  baud_tick,
    input  rxd,
    input  rx_clr,
    output rx_data,
    output rx_valid,
    output rx_ready,
    output overrun,
    output frame_err,
    output rx_busy
  );

  modport master (
    output baud_tick,
    output rxd,
    output rx_clr,
    input  rx_data,
    input  rx_valid,
    input  rx_ready,
    input  overrun,
    input  frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling, sticky ready/overrun
// status and single-cycle data/framing-error strobes.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int TW          = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int SYNC_STAGES = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxd_d;
  logic [1:0]             r_state;
  logic [TW-1:0]          r_tcnt;
  logic [2:0]             r_bcnt;
  logic [7:0]             r_sh;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_ready;
  logic                   r_overrun;
  logic                   r_ferr;
  logic                   r_busy;

  logic                   w_rxd_s;
  logic                   w_fall;
  logic [7:0]             w_sh_shifted;
  logic [1:0]             w_state_next;
  logic [TW-1:0]          w_tcnt_next;
  logic [2:0]             w_bcnt_next;
  logic [7:0]             w_sh_next;
  logic [7:0]             w_data_next;
  logic                   w_ready_next;
  logic                   w_overrun_next;
  logic                   w_good;
  logic                   w_bad;

  assign w_rxd_s = r_sync[SYNC_STAGES-1];
  assign w_fall  = r_rxd_d & ~w_rxd_s;

  // Right shift: the newest bit enters at the MSB so LSB-first data lands in order.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_shift
      assign w_sh_shifted[gi] = r_sh[gi+1];
    end
  endgenerate
  assign w_sh_shifted[7] = w_rxd_s;

  always_comb begin
    w_state_next = r_state;
    w_tcnt_next  = r_tcnt;
    w_bcnt_next  = r_bcnt;
    w_sh_next    = r_sh;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_next = S_START;
          w_tcnt_next  = '0;
        end
      end
      S_START: begin
        if (bus.baud_tick) begin
          if (r_tcnt == T_MID) begin
            w_tcnt_next = '0;
            if (!w_rxd_s) begin
              w_state_next = S_DATA;
              w_bcnt_next  = 3'd0;
            end else begin
              w_state_next = S_IDLE;
            end
          end else begin
            w_tcnt_next = r_tcnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (bus.baud_tick) begin
          if (r_tcnt == T_LAST) begin
            w_sh_next   = w_sh_shifted;
            w_tcnt_next = '0;
            if (r_bcnt == 3'd7) begin
              w_state_next = S_STOP;
            end else begin
              w_bcnt_next = r_bcnt + 3'd1;
            end
          end else begin
            w_tcnt_next = r_tcnt + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (bus.baud_tick) begin
          if (r_tcnt == T_LAST) begin
            w_good       = w_rxd_s;
            w_bad        = ~w_rxd_s;
            w_tcnt_next  = '0;
            w_state_next = S_IDLE;
          end else begin
            w_tcnt_next = r_tcnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tcnt_next  = '0;
      end
    endcase
  end

  // A good frame wins over a simultaneous clear; overrun looks at ready before the clear.
  always_comb begin
    w_data_next    = w_good ? r_sh : r_data;
    w_ready_next   = w_good | (r_ready & ~bus.rx_clr);
    w_overrun_next = (bus.rx_clr ? 1'b0 : r_overrun) | (w_good & r_ready);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync    <= '1;
      r_rxd_d   <= 1'b1;
      r_state   <= S_IDLE;
      r_tcnt    <= '0;
      r_bcnt    <= 3'd0;
      r_sh      <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.rxd};
      r_rxd_d   <= w_rxd_s;
      r_state   <= w_state_next;
      r_tcnt    <= w_tcnt_next;
      r_bcnt    <= w_bcnt_next;
      r_sh      <= w_sh_next;
      r_data    <= w_data_next;
      r_valid   <= w_good;
      r_ready   <= w_ready_next;
      r_overrun <= w_overrun_next;
      r_ferr    <= w_bad;
      r_busy    <= (w_state_next != S_IDLE);
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.rx_ready  = r_ready;
  assign bus.overrun   = r_overrun;
  assign bus.frame_err = r_ferr;
  assign bus.rx_busy   = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frames against a frame-level reference model of the
// receiver's data and status behaviour.
module tb_uart_rx;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT      = OS * TICK_DIV;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_rx_if bus();

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model, updated once per frame / clear pulse.
  logic [7:0] m_data    = 8'h00;
  logic       m_ready   = 1'b0;
  logic       m_overrun = 1'b0;
  int         m_valid   = 0;
  int         m_ferr    = 0;

  // Strobe observations.
  int   n_valid = 0, n_ferr = 0, n_wide = 0, n_busy_rise = 0;
  logic p_valid = 1'b0, p_ferr = 1'b0, p_busy = 1'b0;

  initial begin
    int tc;
    tc = 0;
    bus.baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      bus.baud_tick = (tc == TICK_DIV - 1);
      tc = (tc + 1) % TICK_DIV;
    end
  end

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      n_valid++;
      if (p_valid) n_wide++;
    end
    if (bus.frame_err) begin
      n_ferr++;
      if (p_ferr) n_wide++;
    end
    if (bus.rx_busy && !p_busy) n_busy_rise++;
    p_valid = bus.rx_valid;
    p_ferr  = bus.frame_err;
    p_busy  = bus.rx_busy;
  end

  initial begin
    #600000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    bus.rxd = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    bus.rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop, input logic clr_same_cycle);
    if (stop) begin
      m_valid++;
      m_data = d;
      if (clr_same_cycle) m_overrun = m_ready;
      else if (m_ready) m_overrun = 1'b1;
      m_ready = 1'b1;
    end else begin
      m_ferr++;
    end
  endtask

  task automatic pulse_clr();
    bus.rx_clr = 1'b1;
    @(negedge clk);
    bus.rx_clr = 1'b0;
    @(negedge clk);
    m_ready   = 1'b0;
    m_overrun = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_data"},    {24'h0, bus.rx_data}, {24'h0, m_data});
    check({tag, "_ready"},   {31'h0, bus.rx_ready}, {31'h0, m_ready});
    check({tag, "_overrun"}, {31'h0, bus.overrun}, {31'h0, m_overrun});
    check({tag, "_nvalid"},  n_valid, m_valid);
    check({tag, "_nferr"},   n_ferr, m_ferr);
    check({tag, "_wide"},    n_wide, 0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (bus.rx_busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, {31'h0, bus.rx_busy}, 32'h0);
  endtask

  // Raise rx_clr for exactly the cycle of the stop-bit sample: start is entered
  // on the third edge after the line falls, then 8 + 9*16 ticks to the stop sample.
  task automatic clr_at_stop();
    int n;
    n = 0;
    repeat (3) @(posedge clk);
    while (n < OS / 2 - 1 + 9 * OS) begin
      @(posedge clk);
      if (bus.baud_tick) n++;
    end
    repeat (TICK_DIV) @(negedge clk);
    bus.rx_clr = 1'b1;
    @(negedge clk);
    bus.rx_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int br;
    bus.rxd    = 1'b1;
    bus.rx_clr = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",  {24'h0, bus.rx_data}, 32'h0);
    check("rst_valid", {31'h0, bus.rx_valid}, 32'h0);
    check("rst_ready", {31'h0, bus.rx_ready}, 32'h0);
    check("rst_ovr",   {31'h0, bus.overrun}, 32'h0);
    check("rst_ferr",  {31'h0, bus.frame_err}, 32'h0);
    check("rst_busy",  {31'h0, bus.rx_busy}, 32'h0);
    reset = 1'b1;
    idle(20);

    // Good byte
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1, 1'b0);
    idle(4);
    check_status("a5");

    // Back-to-back with overrun, then clear
    send_frame(8'h00, 1'b1);
    model_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1);
    model_frame(8'hFF, 1'b1, 1'b0);
    idle(4);
    check_status("b2b");
    pulse_clr();
    check_status("clr");

    // Randomized frames with random gaps and clears
    for (int r = 0; r < 6; r++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, 1'b1);
      model_frame(d, 1'b1, 1'b0);
      idle(2);
      check_status($sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) == 1) begin
        pulse_clr();
        check_status($sformatf("rndclr%0d", r));
      end
      idle($urandom_range(0, 40));
    end

    // Framing error after a good byte, then line held low
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b0);
    check_status("ferr");
    br = n_busy_rise;
    repeat (300) @(negedge clk);
    check("hold_low_rise", n_busy_rise, br);
    check("hold_low_busy", {31'h0, bus.rx_busy}, 32'h0);
    idle(2 * BIT);

    // Glitch shorter than half a bit
    br = n_busy_rise;
    bus.rxd = 1'b0;
    repeat (12) @(negedge clk);
    idle(40);
    wait_idle("glitch", 200);
    check("glitch_rise", n_busy_rise, br + 1);
    check_status("glitch");

    // Reset in data bit 4 of 0x5A
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(((8'h5A >> i) & 8'h01) != 0);
    repeat (20) @(negedge clk);
    check("mid_busy", {31'h0, bus.rx_busy}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("mr_data",  {24'h0, bus.rx_data}, 32'h0);
    check("mr_valid", {31'h0, bus.rx_valid}, 32'h0);
    check("mr_ready", {31'h0, bus.rx_ready}, 32'h0);
    check("mr_ovr",   {31'h0, bus.overrun}, 32'h0);
    check("mr_ferr",  {31'h0, bus.frame_err}, 32'h0);
    check("mr_busy",  {31'h0, bus.rx_busy}, 32'h0);
    m_data = 8'h00; m_ready = 1'b0; m_overrun = 1'b0;
    @(negedge clk);
    idle(10);
    reset = 1'b1;
    idle(30);
    send_frame(8'hC3, 1'b1);
    model_frame(8'hC3, 1'b1, 1'b0);
    idle(4);
    check_status("c3");

    // Clear collides with the stop-bit sample
    fork
      send_frame(8'h77, 1'b1);
      clr_at_stop();
    join
    model_frame(8'h77, 1'b1, 1'b1);
    idle(4);
    check_status("coll");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive stage feeding the peripheral block's `UART_RXD` register and its `UART_CON` receive status bit. It synchronises the asynchronous `rxd` line, detects a start bit, and samples 8 data bits LSB-first plus one stop bit using a 16x oversampling tick from the baud-rate generator. On each completed frame it presents the byte with a one-cycle strobe and keeps a sticky ready flag, plus frame-error and overrun status.

## Interface
- `OVERSAMPLE`, 16: baud ticks per bit; must be even, at least 4.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low; clock clk.
- `baud_tick`  in  1  single-cycle pulse at OVERSAMPLE x baud rate, from the baud generator.
- `rxd`  in  1  serial line, idle high, asynchronous to clk.
- `rx_clr`  in  1  clears `rx_ready` and `overrun`; the bus side pulses this when it reads the RX data register.
- `rx_data`  out  8  last good received byte; holds until the next good frame.
- `rx_valid`  out  1  one-cycle strobe when `rx_data` updates.
- `rx_ready`  out  1  sticky: a byte is waiting.
- `overrun`  out  1  sticky: a good byte arrived while `rx_ready` was already 1.
- `frame_err`  out  1  one-cycle strobe when the stop bit samples 0.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- **Input synchroniser:** 2-flop synchroniser on `rxd`, giving `rxd_s`. Both flops reset to 1. One more register, `rxd_d`, holds the previous `rxd_s` for falling-edge detection.
- **Counters:**
  - Tick counter `tcnt`, width log2(OVERSAMPLE). It advances only on `baud_tick`.
  - Bit counter `bcnt`, 3 bits.
  - Shift register `sh`, 8 bits. It shifts right, with the new bit entering at bit 7.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE:**
  - A falling edge (`rxd_d`=1, `rxd_s`=0) moves to START and clears `tcnt`.
  - No edge means stay in IDLE.
  - A line held low does not retrigger.
- **START:** on the `baud_tick` where `tcnt`=OVERSAMPLE/2-1 (mid-bit):
  - `rxd_s`=0: go to DATA; clear `tcnt` and `bcnt`.
  - `rxd_s`=1: glitch; return to IDLE with no output.
- **DATA:** on the `baud_tick` where `tcnt`=OVERSAMPLE-1:
  - Shift `rxd_s` into `sh` and clear `tcnt`.
  - If `bcnt`=7, go to STOP. Otherwise increment `bcnt`.
- **STOP:** on the `baud_tick` where `tcnt`=OVERSAMPLE-1:
  - `rxd_s`=1 (good frame): `rx_data`<=`sh` and pulse `rx_valid`. Set `overrun` if `rx_ready` was 1, then set `rx_ready`.
  - `rxd_s`=0 (framing error): pulse `frame_err`. `rx_data`, `rx_ready` and `overrun` are unchanged.
  - Either way, return to IDLE.
- **Status flags:**
  - Set of `rx_ready` on a good frame in the same cycle as `rx_clr`: set wins, and `overrun` is evaluated against the pre-clear value.
  - `rx_clr` at any other time clears `rx_ready` and `overrun` on the next edge.
- **`baud_tick` gaps:** `baud_tick` absent means the FSM holds its state. There is no timeout.
- **Reset:** `reset` low at any time, including mid-frame, forces:
  - state IDLE; `tcnt`, `bcnt` and `sh` all 0;
  - `rx_data`=8'h00;
  - `rx_valid`, `rx_ready`, `overrun`, `frame_err` and `rx_busy` all 0.
  
  A partial frame is discarded.

## Timing
- `rxd` to `rxd_s` latency: 2 clk. Edge detection takes 1 more clk.
- Start-bit mid-sample lands OVERSAMPLE/2 ticks after the edge is detected. Data bit k is sampled (k+1)·OVERSAMPLE ticks after that.
- All outputs are registered:
  - `rx_valid` / `frame_err` are high for exactly the one clk following the stop-sample `baud_tick` cycle.
  - `rx_data` and `rx_ready` change on that same edge.
- `rx_busy` rises on the edge that enters START. It falls on the edge that returns to IDLE.
- A back-to-back frame is accepted when its start edge arrives any time after the FSM re-enters IDLE.
- The 16x sampling tolerates ±3% baud mismatch.

## Test plan
- **Good byte:** `baud_tick` every 4 clk (bit period 64 clk). Send 0xA5 with a good stop bit.
  - Required: `rx_valid` 1 clk; `rx_data`=0xA5; `rx_ready`=1; `frame_err`=0; `overrun`=0.
- **Back-to-back and overrun:** send 0x00 and then 0xFF with no idle gap and no `rx_clr`.
  - Required: two `rx_valid` pulses; final `rx_data`=0xFF; `overrun`=1.
  - Then pulse `rx_clr`. Required: `rx_ready`=0 and `overrun`=0.
- **Framing error:** send 0x3C with stop bit 0 after a prior good 0x11.
  - Required: `frame_err` 1 clk; no `rx_valid`; `rx_data` stays 0x11.
  - Line held low afterwards: no new start until it goes high and falls again.
- **Glitch rejection:** pulse `rxd` low for 12 clk (3 ticks < half-bit).
  - Required: FSM returns to IDLE; no strobes; `rx_busy` pulses then drops.
- **Reset mid-frame:** assert `reset` low during data bit 4 of 0x5A.
  - Required: all outputs 0 immediately (asynchronous); after release, a fresh 0xC3 is received correctly.
- **Set/clear collision:** assert `rx_clr` in the exact cycle the stop bit of 0x77 is sampled, with `rx_ready`=1 beforehand.
  - Required: `rx_ready`=1 afterwards; `overrun`=1; `rx_data`=0x77.
